// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes,
// data-RAM wait freezing with timeout error, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic             i_ex_memRead,
    input  logic [REG_W-1:0] i_ex_write_addr,
    input  logic             i_ex_branch_tkn,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_flush,
    output logic             o_exmem_en,
    output logic             o_memwb_bubble,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e           r_state;
    state_e           w_state_d;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_d;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_mem_stall;
    logic             w_hazard;

    assign w_hazard = i_ex_memRead && (i_ex_write_addr != '0) &&
                      ((i_ex_write_addr == i_id_rs) ||
                       (i_id_uses_rt && (i_ex_write_addr == i_id_rt)));

    always_comb begin
        w_state_d    = r_state;
        w_wait_cnt_d = r_wait_cnt;
        w_mem_stall  = 1'b0;
        unique case (r_state)
            StRun: begin
                if (i_mem_req && !i_mem_ready) begin
                    w_mem_stall  = 1'b1;
                    w_state_d    = StMemWait;
                    w_wait_cnt_d = r_wait_cnt + 8'd1;
                end
            end
            StMemWait: begin
                if (i_mem_ready) begin
                    w_state_d    = StRun;
                    w_wait_cnt_d = '0;
                end else if (r_wait_cnt >= WaitLast) begin
                    w_mem_stall = 1'b1;
                    w_state_d   = StErr;
                end else begin
                    w_mem_stall  = 1'b1;
                    w_wait_cnt_d = r_wait_cnt + 8'd1;
                end
            end
            StErr: begin
                w_mem_stall = 1'b1;
            end
            default: begin
                w_mem_stall = 1'b1;
                w_state_d   = StErr;
            end
        endcase
    end

    always_comb begin
        o_pc_en        = 1'b1;
        o_ifid_en      = 1'b1;
        o_ifid_flush   = 1'b0;
        o_idex_en      = 1'b1;
        o_idex_flush   = 1'b0;
        o_exmem_en     = 1'b1;
        o_memwb_bubble = 1'b0;
        if (!rst_n) begin
            o_pc_en        = 1'b0;
            o_ifid_en      = 1'b0;
            o_idex_en      = 1'b0;
            o_exmem_en     = 1'b0;
            o_ifid_flush   = 1'b1;
            o_idex_flush   = 1'b1;
            o_memwb_bubble = 1'b1;
        end else if (w_mem_stall) begin
            // Freeze everything upstream of MEM; a pending branch waits in EX.
            o_pc_en        = 1'b0;
            o_ifid_en      = 1'b0;
            o_idex_en      = 1'b0;
            o_exmem_en     = 1'b0;
            o_memwb_bubble = 1'b1;
        end else if (i_ex_branch_tkn) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (w_hazard) begin
            o_pc_en      = 1'b0;
            o_ifid_en    = 1'b0;
            o_idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
            if (!o_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_mem_err   = (r_state == StErr);
    assign o_stall_cnt = r_stall_cnt;

endmodule
